// File: rtl/GEMM_pkg.sv
// Shared types and constants for the fixed-weight systolic GEMV engine.
package GEMM_pkg;

  localparam int unsigned DefaultSaSize = 3;
  localparam int unsigned DefaultWidth  = 8;

  typedef logic [DefaultWidth-1:0] act_t;

  // Diagonal weight matrix loaded at reset: W[row][col] = (row==col) ? (sa_size+1-row) : 0.
  function automatic int unsigned default_weight(int unsigned row, int unsigned col,
                                                 int unsigned sa_size);
    return (row == col) ? (sa_size + 1 - row) : 32'd0;
  endfunction

  function automatic int unsigned latency(int unsigned sa_size);
    return 2 * sa_size;
  endfunction

endpackage

// File: rtl/systolic_array.sv
// Weight-stationary PE grid with input skew and output deskew; fixed 2*SA_SIZE latency.
module systolic_array
  import GEMM_pkg::*;
#(
  parameter int unsigned SA_SIZE                = DefaultSaSize,
  parameter int unsigned WEIGHT_ACTIVATION_SIZE = DefaultWidth
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [WEIGHT_ACTIVATION_SIZE-1:0] activation_inputs  [SA_SIZE],
  output logic [WEIGHT_ACTIVATION_SIZE-1:0] activation_outputs [SA_SIZE]
);

  typedef logic [WEIGHT_ACTIVATION_SIZE-1:0] data_t;

  data_t weights_reg [SA_SIZE][SA_SIZE];
  data_t pe_ins      [SA_SIZE][SA_SIZE];
  data_t pe_outs     [SA_SIZE][SA_SIZE];
  data_t skewed      [SA_SIZE];

  // resetn is active-high; weights are only written while it is asserted.
  always_ff @(posedge clk) begin
    if (resetn) begin
      for (int j = 0; j < int'(SA_SIZE); j++) begin
        for (int i = 0; i < int'(SA_SIZE); i++) begin
          weights_reg[j][i] <= data_t'(default_weight(j, i, SA_SIZE));
        end
      end
    end
  end

  for (genvar i = 0; i < int'(SA_SIZE); i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign skewed[i] = activation_inputs[i];
    end else begin : g_delay
      data_t skew_q [i];
      always_ff @(posedge clk) begin
        if (resetn) begin
          for (int k = 0; k < i; k++) skew_q[k] <= '0;
        end else begin
          skew_q[0] <= activation_inputs[i];
          for (int k = 1; k < i; k++) skew_q[k] <= skew_q[k-1];
        end
      end
      assign skewed[i] = skew_q[i-1];
    end
  end

  for (genvar i = 0; i < int'(SA_SIZE); i++) begin : g_row
    for (genvar j = 0; j < int'(SA_SIZE); j++) begin : g_pe
      data_t act_in, psum_in, act_q, psum_q;

      if (j == 0) begin : g_act_edge
        assign act_in = skewed[i];
      end else begin : g_act_fwd
        assign act_in = pe_ins[i][j-1];
      end

      if (i == 0) begin : g_psum_top
        assign psum_in = '0;
      end else begin : g_psum_down
        assign psum_in = pe_outs[i-1][j];
      end

      always_ff @(posedge clk) begin
        if (resetn) begin
          act_q  <= '0;
          psum_q <= '0;
        end else begin
          act_q  <= act_in;
          psum_q <= psum_in + act_in * weights_reg[i][j];
        end
      end

      assign pe_ins[i][j]  = act_q;
      assign pe_outs[i][j] = psum_q;
    end
  end

  // Column j leaves the grid j cycles late, so it needs SA_SIZE-j more stages to realign.
  for (genvar j = 0; j < int'(SA_SIZE); j++) begin : g_deskew
    localparam int Depth = int'(SA_SIZE) - j;
    data_t deskew_q [Depth];
    always_ff @(posedge clk) begin
      if (resetn) begin
        for (int k = 0; k < Depth; k++) deskew_q[k] <= '0;
      end else begin
        deskew_q[0] <= pe_outs[SA_SIZE-1][j];
        for (int k = 1; k < Depth; k++) deskew_q[k] <= deskew_q[k-1];
      end
    end
    assign activation_outputs[j] = deskew_q[Depth-1];
  end

endmodule

// File: rtl/gemm_fixed_weights_each_cycle.sv
// Top level: systolic GEMV datapath plus the saturating output-valid counter.
module gemm_fixed_weights_each_cycle
  import GEMM_pkg::*;
#(
  parameter int unsigned SA_SIZE                = DefaultSaSize,
  parameter int unsigned WEIGHT_ACTIVATION_SIZE = DefaultWidth
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [WEIGHT_ACTIVATION_SIZE-1:0] activation_inputs  [SA_SIZE],
  output logic [WEIGHT_ACTIVATION_SIZE-1:0] activation_outputs [SA_SIZE],
  output logic                              output_valid
);

  localparam int unsigned Latency    = latency(SA_SIZE);
  localparam int unsigned CountWidth = $clog2(Latency + 1);

  logic [CountWidth-1:0] count_q;

  systolic_array #(
    .SA_SIZE               (SA_SIZE),
    .WEIGHT_ACTIVATION_SIZE(WEIGHT_ACTIVATION_SIZE)
  ) u_SA (
    .clk               (clk),
    .resetn            (resetn),
    .activation_inputs (activation_inputs),
    .activation_outputs(activation_outputs)
  );

  always_ff @(posedge clk) begin
    if (resetn) begin
      count_q <= '0;
    end else if (count_q != CountWidth'(Latency)) begin
      count_q <= count_q + CountWidth'(1);
    end
  end

  assign output_valid = (count_q == CountWidth'(Latency));

endmodule

// File: tb/tb_gemm_fixed_weights_each_cycle.sv
// Scoreboard bench for the fixed-weight GEMV engine (SA_SIZE=3, weights diag(4,3,2)).
module tb_gemm_fixed_weights_each_cycle;

  localparam int S = 3;
  localparam int W = 8;
  localparam int L = 2 * S;

  typedef logic [S-1:0][W-1:0] vec_t;

  logic         clk;
  logic         resetn;
  logic [W-1:0] act_in  [S];
  logic [W-1:0] act_out [S];
  logic         out_valid;

  vec_t exp_q [$];
  vec_t hist  [$];
  int   n_since;
  int   vectors;
  int   miscompares;

  gemm_fixed_weights_each_cycle #(
    .SA_SIZE               (S),
    .WEIGHT_ACTIVATION_SIZE(W)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .activation_inputs (act_in),
    .activation_outputs(act_out),
    .output_valid      (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wt(int row, int col);
    return (row == col) ? (S + 1 - row) : 0;
  endfunction

  function automatic vec_t golden(vec_t x);
    vec_t r;
    int   sum;
    for (int i = 0; i < S; i++) begin
      sum = 0;
      for (int j = 0; j < S; j++) sum = sum + int'(x[j]) * wt(j, i);
      r[i] = W'(sum % 256);
    end
    return r;
  endfunction

  function automatic vec_t outs();
    vec_t v;
    for (int i = 0; i < S; i++) v[i] = act_out[i];
    return v;
  endfunction

  function automatic vec_t mk(int a, int b, int c);
    vec_t v;
    v[0] = W'(a);
    v[1] = W'(b);
    v[2] = W'(c);
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < S; i++) v[i] = W'($urandom_range(0, 255));
    return v;
  endfunction

  // Drive one vector, record its golden result, advance past the edge.
  task automatic cycle(input vec_t x);
    for (int i = 0; i < S; i++) act_in[i] = x[i];
    exp_q.push_back(golden(x));
    hist.push_front(x);
    if (hist.size() > L) void'(hist.pop_back());
    n_since++;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int cycles);
    resetn = 1'b1;
    for (int i = 0; i < S; i++) act_in[i] = '0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    resetn = 1'b0;
    exp_q.delete();
    hist.delete();
    n_since = 0;
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    for (int i = 0; i < S; i++) act_in[i] = 8'h99;
    repeat (2) begin
      @(posedge clk);
      #1;
      vectors++;
      if (outs() !== '0 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state: got out=%h valid=%b want out=0 valid=0", outs(), out_valid);
      end
    end
    resetn = 1'b0;
    exp_q.delete();
    hist.delete();
    n_since = 0;
  endtask

  task automatic test_first_vector();
    vec_t e;
    cycle(mk(2, 5, 0));
    for (int c = 0; c < L + 2; c++) begin
      if (n_since >= L) begin
        e = exp_q.pop_front();
        vectors++;
        if (outs() !== e || out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL first_vector n=%0d: got out=%h valid=%b want out=%h valid=1",
                   n_since, outs(), out_valid, e);
        end
        if (n_since == L) begin
          vectors++;
          if (outs() !== mk(8, 15, 0)) begin
            miscompares++;
            $display("FAIL first_vector_const: got %h want %h", outs(), mk(8, 15, 0));
          end
        end
      end else begin
        vectors++;
        if (out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL valid_timing n=%0d: got valid=%b want 0", n_since, out_valid);
        end
      end
      cycle('0);
    end
  endtask

  task automatic test_back_to_back();
    vec_t e;
    vec_t consts [3];
    consts[0] = mk(8, 15, 2);
    consts[1] = mk(12, 6, 14);
    consts[2] = mk(32, 88, 144);
    apply_reset(1);
    cycle(mk(2, 5, 1));
    cycle(mk(3, 2, 7));
    cycle(mk(200, 200, 200));
    for (int c = 0; c < L + 2; c++) begin
      if (n_since >= L) begin
        e = exp_q.pop_front();
        vectors++;
        if (outs() !== e || out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL back_to_back n=%0d: got out=%h valid=%b want out=%h valid=1",
                   n_since, outs(), out_valid, e);
        end
        if (n_since - L < 3) begin
          vectors++;
          if (outs() !== consts[n_since-L]) begin
            miscompares++;
            $display("FAIL back_to_back_const n=%0d: got %h want %h",
                     n_since, outs(), consts[n_since-L]);
          end
        end
      end else begin
        vectors++;
        if (out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_valid n=%0d: got valid=%b want 0", n_since, out_valid);
        end
      end
      cycle(c == 0 ? mk(1, 2, 3) : '0);
    end
  endtask

  task automatic test_mid_reset();
    vec_t e;
    apply_reset(1);
    repeat (L + 2) cycle(rand_vec());
    resetn = 1'b1;
    for (int i = 0; i < S; i++) act_in[i] = 8'hA5;
    @(posedge clk);
    #1;
    vectors++;
    if (outs() !== '0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_flush: got out=%h valid=%b want out=0 valid=0", outs(), out_valid);
    end
    resetn = 1'b0;
    exp_q.delete();
    hist.delete();
    n_since = 0;
    for (int c = 0; c < L + 4; c++) begin
      cycle(rand_vec());
      if (n_since >= L) begin
        e = exp_q.pop_front();
        vectors++;
        if (outs() !== e || out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL mid_reset_resume n=%0d: got out=%h valid=%b want out=%h valid=1",
                   n_since, outs(), out_valid, e);
        end
      end else begin
        vectors++;
        if (out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL mid_reset_valid n=%0d: got valid=%b want 0", n_since, out_valid);
        end
      end
    end
  endtask

  task automatic test_random_stream();
    vec_t       e;
    vec_t       xh;
    logic [W-1:0] exp_in, exp_ps;
    int         sum;
    apply_reset(2);
    for (int c = 0; c < 40; c++) begin
      cycle(rand_vec());
      if (n_since >= L) begin
        e = exp_q.pop_front();
        vectors++;
        if (outs() !== e || out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL random_stream n=%0d: got out=%h valid=%b want out=%h valid=1",
                   n_since, outs(), out_valid, e);
        end
      end
      for (int i = 0; i < S; i++) begin
        for (int j = 0; j < S; j++) begin
          if (n_since >= i + j + 1) begin
            xh     = hist[i+j];
            exp_in = xh[i];
            sum    = 0;
            for (int k = 0; k <= i; k++) sum = sum + int'(xh[k]) * wt(k, j);
            exp_ps = W'(sum % 256);
            vectors++;
            if (dut.u_SA.pe_ins[i][j] !== exp_in || dut.u_SA.pe_outs[i][j] !== exp_ps) begin
              miscompares++;
              $display("FAIL pe_invariant[%0d][%0d] n=%0d: got in=%h psum=%h want in=%h psum=%h",
                       i, j, n_since, dut.u_SA.pe_ins[i][j], dut.u_SA.pe_outs[i][j],
                       exp_in, exp_ps);
            end
          end
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    n_since     = 0;
    resetn      = 1'b1;
    for (int i = 0; i < S; i++) act_in[i] = '0;
    test_reset();
    test_first_vector();
    test_back_to_back();
    test_mid_reset();
    test_random_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
